// File: rtl/motor_deadtime.sv
// Half-bridge gate driver: turns high/low PWM commands into non-overlapping
// registered gate drives with a programmable dead time and a latched fault path.
module motor_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_pwm_h,
  input  logic            io_pwm_l,
  input  logic            io_en,
  input  logic [DT_W-1:0] io_dt_cycles,
  input  logic            io_fault_n,
  input  logic            io_fault_clr,
  output logic            io_gate_h,
  output logic            io_gate_l,
  output logic            io_fault_o,
  output logic            io_dead_active,
  output logic            io_shoot_err
);

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [DT_W-1:0]        cnt_reg, cnt_next;
  logic [SYNC_STAGES-1:0] fault_sync_reg;
  logic                   fault_synced;
  logic                   cmd_h, cmd_l, dt_zero;
  logic                   shoot_next;
  logic                   gate_h_reg, gate_l_reg, fault_o_reg, dead_reg, shoot_err_reg;

  assign cmd_h        = io_pwm_h & ~io_pwm_l & io_en;
  assign cmd_l        = io_pwm_l & ~io_pwm_h & io_en;
  assign dt_zero      = (io_dt_cycles == '0);
  assign fault_synced = fault_sync_reg[SYNC_STAGES-1];
  // Both commands high is illegal regardless of enable; the flag stays until cleared.
  assign shoot_next   = (io_pwm_h & io_pwm_l) | (shoot_err_reg & ~io_fault_clr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_sync_reg <= '1;
    end else begin
      fault_sync_reg <= {fault_sync_reg[SYNC_STAGES-2:0], io_fault_n};
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!fault_synced) begin
      state_next = FAULT;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_h)      state_next = HIGH;
          else if (cmd_l) state_next = LOW;
        end
        HIGH: begin
          if (!cmd_h) begin
            state_next = dt_zero ? IDLE : DEAD;
            cnt_next   = io_dt_cycles;
          end
        end
        LOW: begin
          if (!cmd_l) begin
            state_next = dt_zero ? IDLE : DEAD;
            cnt_next   = io_dt_cycles;
          end
        end
        DEAD: begin
          // Count only moves down while above one, so it can never wrap.
          if (cnt_reg <= DT_W'(1)) state_next = IDLE;
          else                     cnt_next   = cnt_reg - DT_W'(1);
        end
        FAULT: begin
          if (io_fault_clr) begin
            state_next = dt_zero ? IDLE : DEAD;
            cnt_next   = io_dt_cycles;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are flopped from the next-state decode so they track the state register glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      gate_h_reg    <= 1'b0;
      gate_l_reg    <= 1'b0;
      fault_o_reg   <= 1'b0;
      dead_reg      <= 1'b0;
      shoot_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      gate_h_reg    <= (state_next == HIGH);
      gate_l_reg    <= (state_next == LOW);
      fault_o_reg   <= (state_next == FAULT);
      dead_reg      <= (state_next == DEAD);
      shoot_err_reg <= shoot_next;
    end
  end

  assign io_gate_h      = gate_h_reg;
  assign io_gate_l      = gate_l_reg;
  assign io_fault_o     = fault_o_reg;
  assign io_dead_active = dead_reg;
  assign io_shoot_err   = shoot_err_reg;

endmodule

// File: tb/tb_motor_deadtime.sv
// Bench for motor_deadtime: table vectors, directed dead-time/fault/reset
// sequences, then random stimulus against a timeline reference model.
module tb_motor_deadtime;

  logic       clock;
  logic       reset;
  logic       io_pwm_h, io_pwm_l, io_en;
  logic [7:0] io_dt_cycles;
  logic       io_fault_n, io_fault_clr;
  logic       io_gate_h, io_gate_l, io_fault_o, io_dead_active, io_shoot_err;

  int checks = 0;
  int errors = 0;

  motor_deadtime #(.DT_W(8)) dut (
    .clock(clock), .reset(reset),
    .io_pwm_h(io_pwm_h), .io_pwm_l(io_pwm_l), .io_en(io_en),
    .io_dt_cycles(io_dt_cycles), .io_fault_n(io_fault_n), .io_fault_clr(io_fault_clr),
    .io_gate_h(io_gate_h), .io_gate_l(io_gate_l), .io_fault_o(io_fault_o),
    .io_dead_active(io_dead_active), .io_shoot_err(io_shoot_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: tracks which gate is on and the edge index at which the
  // bridge becomes idle again; dead time is plain arithmetic on edge counts.
  int m_k, m_gate, m_idle_from;   // m_gate: 0 none, 1 high, 2 low
  bit m_fault, m_shoot;
  bit m_fhist[$];                  // fault_n sampled on the last two edges

  task automatic model_reset();
    m_gate = 0; m_fault = 0; m_shoot = 0;
    m_idle_from = m_k;
    m_fhist = {1'b1, 1'b1};
  endtask

  task automatic model_edge();
    bit sf, ch, cl;
    m_k++;
    sf = m_fhist[0];
    void'(m_fhist.pop_front());
    m_fhist.push_back(io_fault_n);
    ch = io_pwm_h && !io_pwm_l && io_en;
    cl = io_pwm_l && !io_pwm_h && io_en;
    if (io_pwm_h && io_pwm_l) m_shoot = 1;
    else if (io_fault_clr)    m_shoot = 0;
    if (!sf) begin
      m_fault = 1; m_gate = 0;
    end else if (m_fault) begin
      if (io_fault_clr) begin m_fault = 0; m_idle_from = m_k + int'(io_dt_cycles); end
    end else if (m_gate == 1) begin
      if (!ch) begin m_gate = 0; m_idle_from = m_k + int'(io_dt_cycles); end
    end else if (m_gate == 2) begin
      if (!cl) begin m_gate = 0; m_idle_from = m_k + int'(io_dt_cycles); end
    end else if (m_k > m_idle_from) begin
      if (ch)      m_gate = 1;
      else if (cl) m_gate = 2;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, input logic l, input logic en, input logic [7:0] dt,
                       input logic fn, input logic clr);
    io_pwm_h = h; io_pwm_l = l; io_en = en; io_dt_cycles = dt;
    io_fault_n = fn; io_fault_clr = clr;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic apply_reset();
    assert_reset();
    release_reset();
  endtask

  // Counts consecutive dead cycles starting with the current one, bounded.
  task automatic count_dead(output int n);
    n = io_dead_active ? 1 : 0;
    for (int i = 0; i < 20 && io_dead_active; i++) begin
      step();
      if (io_dead_active) n++;
    end
  endtask

  typedef struct {
    logic [2:0] cmd;   // {pwm_h, pwm_l, en}
    logic [7:0] dt;
    logic [1:0] fc;    // {fault_n, fault_clr}
    logic [4:0] exp;   // {gate_h, gate_l, fault_o, dead_active, shoot_err}
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] cmd, input logic [7:0] dt,
                         input logic [1:0] fc, input logic [4:0] exp);
    vec_t v;
    v.cmd = cmd; v.dt = dt; v.fc = fc; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    int n, cmd_sel, fault_left;
    logic ph, pl;

    reset = 1'b0;
    m_k = 0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    #1;
    chk("rst_gate_h", io_gate_h, 1'b0);
    chk("rst_gate_l", io_gate_l, 1'b0);
    chk("rst_fault_o", io_fault_o, 1'b0);
    chk("rst_dead", io_dead_active, 1'b0);
    chk("rst_shoot", io_shoot_err, 1'b0);
    release_reset();

    add_vec(3'b101, 8'd2, 2'b10, 5'b10000);
    add_vec(3'b101, 8'd2, 2'b10, 5'b10000);
    add_vec(3'b011, 8'd2, 2'b10, 5'b00010);
    add_vec(3'b011, 8'd2, 2'b10, 5'b00010);
    add_vec(3'b011, 8'd2, 2'b10, 5'b00000);
    add_vec(3'b011, 8'd2, 2'b10, 5'b01000);
    add_vec(3'b111, 8'd2, 2'b10, 5'b00011);
    add_vec(3'b001, 8'd2, 2'b10, 5'b00011);
    add_vec(3'b100, 8'd2, 2'b10, 5'b00001);
    add_vec(3'b100, 8'd2, 2'b10, 5'b00001);
    add_vec(3'b000, 8'd2, 2'b11, 5'b00000);
    add_vec(3'b110, 8'd2, 2'b11, 5'b00001);
    add_vec(3'b101, 8'd2, 2'b10, 5'b10001);
    add_vec(3'b100, 8'd0, 2'b10, 5'b00001);
    add_vec(3'b011, 8'd0, 2'b11, 5'b01000);
    foreach (vecs[i]) begin
      drive(vecs[i].cmd[2], vecs[i].cmd[1], vecs[i].cmd[0], vecs[i].dt, vecs[i].fc[1], vecs[i].fc[0]);
      step();
      chk($sformatf("vec%0d_gate_h", i), io_gate_h, vecs[i].exp[4]);
      chk($sformatf("vec%0d_gate_l", i), io_gate_l, vecs[i].exp[3]);
      chk($sformatf("vec%0d_fault_o", i), io_fault_o, vecs[i].exp[2]);
      chk($sformatf("vec%0d_dead", i), io_dead_active, vecs[i].exp[1]);
      chk($sformatf("vec%0d_shoot", i), io_shoot_err, vecs[i].exp[0]);
      $display("vec %0d: gates=%b%b fault=%b dead=%b shoot=%b", i,
               io_gate_h, io_gate_l, io_fault_o, io_dead_active, io_shoot_err);
    end

    // Fault during HIGH, clear while still faulted, then proper recovery.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0);
    step();
    chk("flt_pre_gate_h", io_gate_h, 1'b1);
    io_fault_n = 1'b0;
    step(); step(); step();
    chk("flt_gate_h_low", io_gate_h, 1'b0);
    chk("flt_fault_o", io_fault_o, 1'b1);
    io_fault_clr = 1'b1;
    step(); step();
    chk("flt_hold", io_fault_o, 1'b1);
    io_fault_n = 1'b1; io_fault_clr = 1'b0;
    step(); step();
    chk("flt_wait_clr", io_fault_o, 1'b1);
    io_fault_clr = 1'b1;
    step();
    chk("flt_exit_fault", io_fault_o, 1'b0);
    io_fault_clr = 1'b0; io_pwm_h = 1'b0;
    count_dead(n);
    chk_int("flt_dead_len", n, 3);
    chk("flt_idle_gate_h", io_gate_h, 1'b0);
    $display("seq fault: dead cycles after clear = %0d", n);

    // Dead-time value changed mid-DEAD only affects the next dead period.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0);
    step();
    io_pwm_h = 1'b0;
    step();
    io_dt_cycles = 8'd1;
    count_dead(n);
    chk_int("dt_change_cur", n, 5);
    io_pwm_h = 1'b1;
    step();
    chk("dt_change_high", io_gate_h, 1'b1);
    io_pwm_h = 1'b0;
    step();
    count_dead(n);
    chk_int("dt_change_next", n, 1);
    $display("seq dt change: next dead period = %0d", n);

    // Asynchronous reset drops gates at once; first edge after release is IDLE.
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0);
    step();
    assert_reset();
    chk("arst_high_gate_h", io_gate_h, 1'b0);
    release_reset();
    step();
    io_pwm_h = 1'b0;
    step();
    chk("arst_dead_pre", io_dead_active, 1'b1);
    assert_reset();
    chk("arst_dead_gate_h", io_gate_h, 1'b0);
    chk("arst_dead_gate_l", io_gate_l, 1'b0);
    chk("arst_dead_dead", io_dead_active, 1'b0);
    release_reset();
    drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
    step();
    chk("arst_first_edge_l", io_gate_l, 1'b1);
    // dt=0 switch: gate falls this edge, the other rises on the next.
    drive(1'b1, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    step();
    chk("dt0_both_low_l", io_gate_l, 1'b0);
    chk("dt0_both_low_h", io_gate_h, 1'b0);
    step();
    chk("dt0_gate_h", io_gate_h, 1'b1);
    $display("seq reset/dt0: gate_h=%b gate_l=%b", io_gate_h, io_gate_l);

    // Random stimulus against the reference model.
    apply_reset();
    cmd_sel = 0; fault_left = 0;
    drive(1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) cmd_sel = int'($urandom_range(0, 2));
      ph = (cmd_sel == 1); pl = (cmd_sel == 2);
      if ($urandom_range(0, 39) == 0) begin ph = 1'b1; pl = 1'b1; end
      io_pwm_h = ph; io_pwm_l = pl;
      io_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) io_dt_cycles = 8'($urandom_range(0, 6));
      if (fault_left > 0) begin
        io_fault_n = 1'b0; fault_left--;
      end else begin
        io_fault_n = 1'b1;
        if ($urandom_range(0, 299) == 0) fault_left = int'($urandom_range(1, 6));
      end
      io_fault_clr = ($urandom_range(0, 7) == 0);
      step();
      chk("rnd_gate_h", io_gate_h, m_gate == 1 && !m_fault);
      chk("rnd_gate_l", io_gate_l, m_gate == 2 && !m_fault);
      chk("rnd_fault_o", io_fault_o, m_fault);
      chk("rnd_dead", io_dead_active, !m_fault && m_gate == 0 && m_k < m_idle_from);
      chk("rnd_shoot", io_shoot_err, m_shoot);
      chk("rnd_no_overlap", io_gate_h & io_gate_l, 1'b0);
      if (i % 1000 == 999) begin
        apply_reset();
        $display("random: %0d cycles done, %0d errors so far", i + 1, errors);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
